ble_at_responder: RTL and testbench
===================================

// Module: ble_at_responder
// PURPOSE
// Synthesizable HM-10-style AT command responder: the module side of the BLE setup link.
// Consumes command bytes from the setup transmitter's byte stream and buffers one line up to LF.
// Replies "OK", "OK+<suffix>" or "ERROR" on its own byte stream.
// Used for FPGA loopback self-test and simulation in place of the physical BLE module.
// PARAMETERS
// MAX_LEN     32  max stored line bytes (CR/LF excluded); must be >= 4
// RESP_DELAY  16  idle cycles between line end and first response byte (0 allowed)
// RESP_CRLF   0   1: append "\r\n" after every response
// PORTS
// clk         in   1  system clock
// rst         in   1  synchronous reset, active-high
// rx_data     in   8  command byte from host TX path
// rx_valid    in   1  rx_data valid
// rx_ready    out  1  responder accepts byte (transfer = rx_valid & rx_ready)
// inject_err  in   1  sampled in EVAL: 1 forces "ERROR" reply
// tx_data     out  8  response byte
// tx_valid    out  1  tx_data valid; held with stable data until tx_ready
// tx_ready    in   1  downstream accepts byte
// busy        out  1  high in any state other than COLLECT
// cmd_count   out  8  lines answered "OK..." since reset; wraps 255->0
// err_count   out  8  lines answered "ERROR" since reset; wraps 255->0
// BEHAVIOUR
// - One clock (clk). Reset synchronous, active-high; applies from any state, even mid-line or mid-reply.
// - Reset values: rx_ready=1, tx_valid=0, tx_data=0, busy=0, cmd_count=0, err_count=0.
// - Reset clears the buffer, length, overflow flag, delay counter and reply index; state returns to COLLECT.
// - States: COLLECT -> EVAL -> DELAY -> REPLY -> COLLECT.
// - COLLECT: rx_ready=1. Per accepted byte:
//   - LF (0x0A): go to EVAL.
//   - CR (0x0D): set pending_cr, not stored. A following non-LF byte stores the CR first, then that byte.
//   - Other bytes: stored at buf[len], len++, while len < MAX_LEN.
//   - Overflow: if len == MAX_LEN, the byte is dropped and ovf is set. Collection continues until LF.
// - EVAL: one cycle, rx_ready=0. Reply is chosen by the first rule that matches:
//   1. inject_err=1, ovf=1 or len==0: reply ERROR.
//   2. len==2 and buf=="AT": reply OK.
//   3. len>=3 and buf[0:2]=="AT+": reply OK+ followed by buf[3..len-1] in order.
//   4. Anything else: reply ERROR.
// - Counter update: err_count++ or cmd_count++ is registered in EVAL.
// - DELAY: counts RESP_DELAY cycles; when RESP_DELAY=0, goes straight to REPLY.
// - REPLY: emits reply bytes in order, then "\r\n" if RESP_CRLF=1.
//   - The byte index advances only on tx_valid & tx_ready.
//   - tx_valid drops in the cycle after the last byte transfer.
//   - State returns to COLLECT with len, ovf and pending_cr cleared.
// - rx_ready=0 in EVAL, DELAY and REPLY. Bytes offered then are not accepted and stay held upstream.
// - Latency: with RESP_DELAY=D, the first tx_valid is asserted 2+D cycles after the LF transfer cycle.
// - Reply timing: with tx_ready tied high, the reply streams one byte per cycle.
// - Minimum gap: rx_ready reasserts one cycle after the last reply byte transfers.
// - Byte index width: clog2(MAX_LEN+3). Counters wrap silently.
// TESTING
// 1. "AT\r\n", D=16, tx_ready=1 -> first tx_valid 18 cycles after LF; "O","K"; cmd_count=1.
// 2. "AT+NAMEX\r\n" -> "OK+NAMEX" (8 bytes); cmd_count increments.
// 3. "XYZ\n", then "\r\n" -> "ERROR", "ERROR"; err_count=2; cmd_count unchanged.
// 4. 40 bytes "AT+AAA..." then "\r\n", MAX_LEN=32 -> "ERROR"; the next "AT\r\n" still yields "OK".
// 5. Backpressure: tx_ready toggled 1/0 during "OK+BAUD" -> byte order exact; tx_data stable while stalled.
// 6. Other edge cases:
//   - rst asserted mid-reply -> tx_valid=0 and counters 0 next cycle; the next "AT\r\n" gives "OK".
//   - inject_err=1 with "AT\r\n" -> "ERROR".
//   - RESP_CRLF=1 -> reply ends 0x0D,0x0A.

Source files
------------

// File: rtl/ble_at_responder.sv
// rtl/ble_at_responder.sv - HM-10-style AT command responder: buffers one line, replies OK / OK+<suffix> / ERROR.
module ble_at_responder #(
    parameter int MAX_LEN    = 32,
    parameter int RESP_DELAY = 16,
    parameter int RESP_CRLF  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic       inject_err,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] cmd_count,
    output logic [7:0] err_count
);

    localparam int IW = $clog2(MAX_LEN + 3);
    localparam int BW = $clog2(MAX_LEN);
    localparam int DW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam logic [IW-1:0] MAX_L  = IW'(MAX_LEN);
    localparam logic [IW-1:0] CRLF_N = (RESP_CRLF != 0) ? IW'(2) : IW'(0);
    localparam logic [DW-1:0] D_LAST = DW'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);

    typedef enum logic [1:0] {COLLECT, EVAL, DELAY, REPLY} state_t;
    typedef enum logic [1:0] {R_OK, R_OKP, R_ERR} kind_t;

    state_t        state;
    kind_t         kind, eval_kind, sel_kind;
    logic [7:0]    line_buf [MAX_LEN];
    logic [IW-1:0] len, len_p1, body, eval_body, sel_body, sel_idx, idx, tot;
    logic          ovf, pending_cr;
    logic [DW-1:0] dcnt;
    logic [7:0]    sel_byte;

    assign len_p1 = len + IW'(1);
    assign tot    = body + CRLF_N;

    always_comb begin
        eval_kind = R_ERR;
        eval_body = IW'(5);
        if (inject_err || ovf || len == '0) begin
            eval_kind = R_ERR;
        end else if (len == IW'(2) && line_buf[0] == 8'h41 && line_buf[1] == 8'h54) begin
            eval_kind = R_OK;
            eval_body = IW'(2);
        end else if (len >= IW'(3) && line_buf[0] == 8'h41 && line_buf[1] == 8'h54
                     && line_buf[2] == 8'h2B) begin
            eval_kind = R_OKP;
            eval_body = len;
        end
    end

    // Byte for the next slot to load into tx_data: slot 0 when starting a reply, idx+1 while streaming.
    always_comb begin
        sel_idx  = (state == REPLY) ? idx + IW'(1) : '0;
        sel_kind = (state == EVAL) ? eval_kind : kind;
        sel_body = (state == EVAL) ? eval_body : body;
        sel_byte = 8'h0A;
        if (sel_idx == sel_body) begin
            sel_byte = 8'h0D;
        end else if (sel_idx < sel_body) begin
            case (sel_kind)
                R_OK:    sel_byte = (sel_idx == '0) ? 8'h4F : 8'h4B;
                R_OKP: begin
                    if (sel_idx == IW'(0))      sel_byte = 8'h4F;
                    else if (sel_idx == IW'(1)) sel_byte = 8'h4B;
                    else if (sel_idx == IW'(2)) sel_byte = 8'h2B;
                    else if (sel_idx < MAX_L)   sel_byte = line_buf[sel_idx[BW-1:0]];
                end
                default: begin
                    if (sel_idx == IW'(0))      sel_byte = 8'h45;
                    else if (sel_idx == IW'(3)) sel_byte = 8'h4F;
                    else                        sel_byte = 8'h52;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            kind       <= R_ERR;
            len        <= '0;
            body       <= '0;
            idx        <= '0;
            ovf        <= 1'b0;
            pending_cr <= 1'b0;
            dcnt       <= '0;
            rx_ready   <= 1'b1;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            cmd_count  <= 8'h00;
            err_count  <= 8'h00;
            for (int j = 0; j < MAX_LEN; j++) line_buf[j] <= 8'h00;
        end else begin
            case (state)
                COLLECT: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h0A) begin
                            state      <= EVAL;
                            rx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            pending_cr <= 1'b0;
                        end else begin
                            // A held CR is only committed once we know it is not the line terminator.
                            if (pending_cr) begin
                                if (len < MAX_L) begin
                                    line_buf[len[BW-1:0]] <= 8'h0D;
                                    len <= len_p1;
                                end else begin
                                    ovf <= 1'b1;
                                end
                                if (rx_data != 8'h0D) begin
                                    if (len_p1 < MAX_L) begin
                                        line_buf[len_p1[BW-1:0]] <= rx_data;
                                        len <= len + IW'(2);
                                    end else begin
                                        ovf <= 1'b1;
                                    end
                                end
                            end else if (rx_data != 8'h0D) begin
                                if (len < MAX_L) begin
                                    line_buf[len[BW-1:0]] <= rx_data;
                                    len <= len_p1;
                                end else begin
                                    ovf <= 1'b1;
                                end
                            end
                            pending_cr <= (rx_data == 8'h0D);
                        end
                    end
                end
                EVAL: begin
                    kind <= eval_kind;
                    body <= eval_body;
                    if (eval_kind == R_ERR) err_count <= err_count + 8'd1;
                    else                    cmd_count <= cmd_count + 8'd1;
                    if (RESP_DELAY == 0) begin
                        state    <= REPLY;
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= sel_byte;
                    end else begin
                        state <= DELAY;
                        dcnt  <= '0;
                    end
                end
                DELAY: begin
                    if (dcnt == D_LAST) begin
                        state    <= REPLY;
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= sel_byte;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    if (tx_ready) begin
                        if (idx + IW'(1) < tot) begin
                            idx     <= idx + IW'(1);
                            tx_data <= sel_byte;
                        end else begin
                            state      <= COLLECT;
                            tx_valid   <= 1'b0;
                            rx_ready   <= 1'b1;
                            busy       <= 1'b0;
                            len        <= '0;
                            ovf        <= 1'b0;
                            pending_cr <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_at_responder.sv
// tb/tb_ble_at_responder.sv - randomized line/reply bench for ble_at_responder against a string-level model.
module tb_ble_at_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rx_data    [2];
    logic       rx_valid   [2];
    logic       rx_ready   [2];
    logic       inject_err [2];
    logic [7:0] tx_data    [2];
    logic       tx_valid   [2];
    logic       tx_ready   [2];
    logic       busy       [2];
    logic [7:0] cmd_count  [2];
    logic [7:0] err_count  [2];

    int checks = 0;
    int errors = 0;
    int exp_cmd [2];
    int exp_err [2];

    ble_at_responder #(.MAX_LEN(32), .RESP_DELAY(16), .RESP_CRLF(0)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
        .inject_err(inject_err[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .cmd_count(cmd_count[0]), .err_count(err_count[0])
    );

    ble_at_responder #(.MAX_LEN(8), .RESP_DELAY(0), .RESP_CRLF(1)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
        .inject_err(inject_err[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .cmd_count(cmd_count[1]), .err_count(err_count[1])
    );

    function automatic int dly(input int u);
        return (u == 0) ? 16 : 0;
    endfunction

    function automatic int maxl(input int u);
        return (u == 0) ? 32 : 8;
    endfunction

    function automatic bit crlf(input int u);
        return (u == 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_q(input string s, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    // Reference: the stored line is the raw line minus a CR sitting directly before LF.
    task automatic model(input logic [7:0] raw[$], input bit inj, input int ml, input bit cr,
                         output logic [7:0] exp_q[$], output bit ok);
        logic [7:0] s[$];
        s = raw;
        if (s.size() > 0 && s[s.size()-1] == 8'h0D) void'(s.pop_back());
        exp_q.delete();
        ok = 1'b0;
        if (!inj && s.size() <= ml && s.size() == 2 && s[0] == 8'h41 && s[1] == 8'h54) begin
            ok = 1'b1;
            exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
        end else if (!inj && s.size() <= ml && s.size() >= 3 && s[0] == 8'h41 && s[1] == 8'h54
                     && s[2] == 8'h2B) begin
            ok = 1'b1;
            exp_q.push_back(8'h4F); exp_q.push_back(8'h4B); exp_q.push_back(8'h2B);
            for (int i = 3; i < s.size(); i++) exp_q.push_back(s[i]);
        end else begin
            to_q("ERROR", exp_q);
        end
        if (cr) begin
            exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        end
    endtask

    task automatic send_byte(input int u, input logic [7:0] b);
        int n;
        n = 0;
        rx_data[u]  = b;
        rx_valid[u] = 1'b1;
        while (!rx_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid[u] = 1'b0;
    endtask

    task automatic run_line(input int u, input logic [7:0] raw[$], input bit inj, input int mode);
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        logic [7:0] held;
        bit ok, bad, stalled;
        int cyc, first;
        model(raw, inj, maxl(u), crlf(u), exp_q, ok);
        inject_err[u] = inj;
        foreach (raw[i]) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send_byte(u, raw[i]);
        end
        send_byte(u, 8'h0A);
        cyc = 1; first = -1; bad = 1'b0; stalled = 1'b0; held = 8'h00;
        while (got.size() < exp_q.size() && cyc < 300) begin
            if (rx_ready[u] || !busy[u]) bad = 1'b1;
            if (tx_valid[u]) begin
                if (first < 0) first = cyc;
                if (stalled && tx_data[u] !== held) bad = 1'b1;
            end else if (first >= 0) begin
                bad = 1'b1;
                break;
            end
            tx_ready[u] = (mode == 0) || (mode == 1 && $urandom_range(0, 1) == 1) ||
                          (mode == 2 && cyc % 2 == 0);
            if (tx_valid[u] && tx_ready[u]) begin
                got.push_back(tx_data[u]);
                stalled = 1'b0;
            end else if (tx_valid[u]) begin
                stalled = 1'b1;
                held = tx_data[u];
            end
            @(negedge clk);
            cyc++;
        end
        inject_err[u] = 1'b0;
        tx_ready[u]   = 1'b1;
        if (ok) exp_cmd[u]++; else exp_err[u]++;
        check($sformatf("u%0d_latency", u), first, 2 + dly(u));
        check($sformatf("u%0d_reply_len", u), got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("u%0d_byte%0d", u, i), (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF,
                  {24'd0, exp_q[i]});
        check($sformatf("u%0d_handshake", u), bad, 0);
        check($sformatf("u%0d_tx_valid_after", u), tx_valid[u], 1'b0);
        check($sformatf("u%0d_rx_ready_after", u), rx_ready[u], 1'b1);
        check($sformatf("u%0d_busy_after", u), busy[u], 1'b0);
        check($sformatf("u%0d_cmd_count", u), cmd_count[u], exp_cmd[u] & 255);
        check($sformatf("u%0d_err_count", u), err_count[u], exp_err[u] & 255);
    endtask

    task automatic rand_line(input int u, output logic [7:0] q[$]);
        int k, n;
        q.delete();
        k = $urandom_range(0, 4);
        if (k == 0) begin
            q.push_back(8'h41); q.push_back(8'h54);
        end else if (k == 1 || k == 3) begin
            q.push_back(8'h41); q.push_back(8'h54); q.push_back(8'h2B);
            n = $urandom_range(0, maxl(u) + 3);
            for (int i = 0; i < n; i++) q.push_back(8'(8'h41 + $urandom_range(0, 25)));
            if (k == 3 && n > 0) q[$urandom_range(3, q.size() - 1)] = 8'h0D;
        end else if (k == 2) begin
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(32, 126)));
        end
        if ($urandom_range(0, 1) == 1) q.push_back(8'h0D);
    endtask

    initial begin
        logic [7:0] q[$];
        int n;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            rx_data[u] = 8'h00; rx_valid[u] = 1'b0; inject_err[u] = 1'b0; tx_ready[u] = 1'b1;
            exp_cmd[u] = 0; exp_err[u] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_ready[0], 1'b1);
        check("rst_tx_valid", tx_valid[0], 1'b0);
        check("rst_tx_data", tx_data[0], 8'h00);
        check("rst_busy", busy[0], 1'b0);
        check("rst_cmd_count", cmd_count[0], 8'h00);
        check("rst_err_count", err_count[0], 8'h00);
        rst = 1'b0;
        @(negedge clk);

        to_q("AT\r", q);        run_line(0, q, 1'b0, 0);
        to_q("AT+NAMEX\r", q);  run_line(0, q, 1'b0, 0);
        to_q("XYZ", q);         run_line(0, q, 1'b0, 0);
        to_q("\r", q);          run_line(0, q, 1'b0, 0);
        to_q("AT+", q);
        for (int i = 0; i < 37; i++) q.push_back(8'h41);
        q.push_back(8'h0D);     run_line(0, q, 1'b0, 0);
        to_q("AT\r", q);        run_line(0, q, 1'b0, 0);
        to_q("AT+BAUD\r", q);   run_line(0, q, 1'b0, 2);
        to_q("AT+BAUD\r", q);   run_line(0, q, 1'b0, 1);
        to_q("AT\r", q);        run_line(0, q, 1'b1, 0);

        to_q("AT+NAMEX", q);
        foreach (q[i]) send_byte(0, q[i]);
        send_byte(0, 8'h0A);
        n = 0;
        while (!tx_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_reply_started", tx_valid[0], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx_valid", tx_valid[0], 1'b0);
        check("mid_rst_cmd_count", cmd_count[0], 8'h00);
        check("mid_rst_err_count", err_count[0], 8'h00);
        check("mid_rst_rx_ready", rx_ready[0], 1'b1);
        for (int u = 0; u < 2; u++) begin
            exp_cmd[u] = 0; exp_err[u] = 0;
        end
        to_q("AT\r", q);        run_line(0, q, 1'b0, 0);

        to_q("AT\r", q);        run_line(1, q, 1'b0, 0);
        to_q("AT+12345\r", q);  run_line(1, q, 1'b0, 1);
        to_q("AT+123456\r", q); run_line(1, q, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            int u;
            u = i % 2;
            rand_line(u, q);
            run_line(u, q, $urandom_range(0, 7) == 0, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
